traffic_light_controller: RTL and testbench
===========================================

Name: traffic_light_controller

Overview:
- Phase sequencer for a two-road intersection: north-south main road, east-west side road, and a pedestrian crossing.
- Owns an internal saturating down-counter phase timer, loaded with the duration of each phase on entry.
- Advances a state machine when the timer expires and a service request is pending.
- Drives the lamp outputs consumed by the display logic and exports phase and remaining time for debug and top-level display.

Parameters:
- COUNT_SIZE, 5, width of phase timer and duration parameters.
- GREEN_TIME, 20, minimum green duration in ticks (NS and EW); must be 1..2^COUNT_SIZE-1.
- YELLOW_TIME, 4, yellow duration in ticks; must be ≥1.
- ALLRED_TIME, 2, all-red clearance duration in ticks; must be ≥1.
- WALK_TIME, 10, pedestrian walk duration in ticks; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  one-cycle timebase enable (e.g. 1 Hz strobe); the timer only moves on tick.
- ew_sensor  in  1  vehicle present on the EW approach; level, sampled every clk.
- ped_req  in  1  pedestrian button; level or pulse, sampled every clk.
- ns_light  out  3  {red,yellow,green} one-hot for the NS road.
- ew_light  out  3  {red,yellow,green} one-hot for the EW road.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding.
- time_left  out  COUNT_SIZE  current timer value.

Behaviour:
- States and encodings:
  - NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5, WALK=6.
  - Code 7 is illegal and recovers to NS_GREEN on the next clk, with the timer loaded to GREEN_TIME.
- Reset (asynchronous, immediate):
  - phase=NS_GREEN, time_left=GREEN_TIME, both pending flags cleared.
  - ns_light=001, ew_light=100, walk=0.
  - Reset asserted mid-phase aborts that phase immediately.
- Timer:
  - On every state entry, time_left is loaded with that state's duration.
  - Otherwise time_left decrements by 1 on each clk where tick=1 and time_left>0.
  - time_left saturates at 0 and never wraps.
  - The timer is expired when time_left==0.
- Request latches:
  - ew_pend is set on any clk with ew_sensor=1, except while in EW_GREEN, where the input is ignored. It is cleared on the edge that enters EW_GREEN.
  - ped_pend is set on any clk with ped_req=1, except while in WALK, where the input is ignored. It is cleared on the edge that enters WALK.
  - A request asserted on the same edge as entry into its service state is dropped, because the state is already serving it.
- Transitions (evaluated every clk, not only on tick; take effect on the same edge that loads the new duration):
  - NS_GREEN: when expired and (ew_pend or ped_pend), go to NS_YELLOW. Otherwise stay in NS_GREEN indefinitely; the main road rests in green.
  - NS_YELLOW: when expired, go to ALLRED_A.
  - ALLRED_A: when expired, go to EW_GREEN if ew_pend, else WALK.
  - EW_GREEN: when expired, go to EW_YELLOW unconditionally (no rest on the side road).
  - EW_YELLOW: when expired, go to ALLRED_B.
  - ALLRED_B: when expired, go to WALK if ped_pend, else NS_GREEN.
  - WALK: when expired, go to NS_GREEN.
- Outputs (registered, decoded from the state register; no combinational path from inputs to outputs):
  - ns_light is green in NS_GREEN, yellow in NS_YELLOW, red otherwise.
  - ew_light is green in EW_GREEN, yellow in EW_YELLOW, red otherwise.
  - walk=1 only in WALK, where both roads are red.
- Safety invariant: ns_light and ew_light are never simultaneously non-red.
- Phase duration: a phase of duration D lasts exactly D ticks, plus the clk cycles from the D-th tick to the transition edge. With tick tied high, that is D+1 clk cycles.
- Simultaneous events: tick and state entry on the same edge means the load wins. ew_pend and ped_pend both set in NS_GREEN means EW is served first, then WALK via ALLRED_B.

Test Plan:
- Common setup: GREEN=3, YELLOW=2, ALLRED=1, WALK=2, tick=1 every cycle.
- Reset, no requests for 50 cycles -> phase stays 0, ns_light=001, ew_light=100, walk=0, time_left settles at 0.
- Pulse ew_sensor at cycle 1 -> sequence 0(4 cyc), 1(3), 2(2), 3(4), 4(3), 5(2), 0; ew_light=001 only during phase 3; no WALK.
- Pulse ped_req only -> sequence 0, 1, 2, 6(3 cyc, walk=1, both red), 0; ped_req pulsed during WALK produces no second WALK.
- ew_sensor and ped_req together -> 0, 1, 2, 3, 4, 5, 6, 0; walk=1 only in phase 6.
- tick every 4th clk, ew_sensor held -> time_left decrements once per tick and never underflows; phase 0 ends 3 ticks after entry.
- Assert rst during phase 3 for 1 cycle -> outputs return immediately to NS green and time_left=3; pending flags cleared. Continuously assert the invariant that ns_light and ew_light are never both non-100.

Source files
------------

// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer with pedestrian phase.
// A per-phase down-counter times each phase, and latched requests decide where the next phase goes.
module traffic_light_controller #(
  parameter int COUNT_SIZE  = 5,
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  ew_sensor,
  input  logic                  ped_req,
  output logic [2:0]            ns_light,
  output logic [2:0]            ew_light,
  output logic                  walk,
  output logic [2:0]            phase,
  output logic [COUNT_SIZE-1:0] time_left
);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALLRED_A  = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALLRED_B  = 3'd5,
    S_WALK      = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_t;

  localparam logic [COUNT_SIZE-1:0] GREEN_LD  = COUNT_SIZE'(GREEN_TIME);
  localparam logic [COUNT_SIZE-1:0] YELLOW_LD = COUNT_SIZE'(YELLOW_TIME);
  localparam logic [COUNT_SIZE-1:0] ALLRED_LD = COUNT_SIZE'(ALLRED_TIME);
  localparam logic [COUNT_SIZE-1:0] WALK_LD   = COUNT_SIZE'(WALK_TIME);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t                  state_q, state_d;
  logic [COUNT_SIZE-1:0]   time_q, time_d;
  logic                    ew_pend_q, ew_pend_d;
  logic                    ped_pend_q, ped_pend_d;
  logic [2:0]              ns_light_q, ns_light_d;
  logic [2:0]              ew_light_q, ew_light_d;
  logic                    walk_q, walk_d;
  logic                    expired;
  logic                    entering;

  function automatic logic [COUNT_SIZE-1:0] duration(input state_t s);
    case (s)
      S_NS_YELLOW, S_EW_YELLOW: duration = YELLOW_LD;
      S_ALLRED_A, S_ALLRED_B:   duration = ALLRED_LD;
      S_WALK:                   duration = WALK_LD;
      default:                  duration = GREEN_LD;
    endcase
  endfunction

  always_comb begin
    expired = (time_q == '0);
    state_d = state_q;
    case (state_q)
      S_NS_GREEN:  if (expired && (ew_pend_q || ped_pend_q)) state_d = S_NS_YELLOW;
      S_NS_YELLOW: if (expired) state_d = S_ALLRED_A;
      S_ALLRED_A:  if (expired) state_d = ew_pend_q ? S_EW_GREEN : S_WALK;
      S_EW_GREEN:  if (expired) state_d = S_EW_YELLOW;
      S_EW_YELLOW: if (expired) state_d = S_ALLRED_B;
      S_ALLRED_B:  if (expired) state_d = ped_pend_q ? S_WALK : S_NS_GREEN;
      S_WALK:      if (expired) state_d = S_NS_GREEN;
      default:     state_d = S_NS_GREEN;
    endcase

    // A state entry always reloads the timer, even if tick is high on the same edge
    entering = (state_d != state_q);
    time_d   = time_q;
    if (entering)
      time_d = duration(state_d);
    else if (tick && !expired)
      time_d = time_q - 1'b1;

    ew_pend_d = ew_pend_q;
    if (entering && state_d == S_EW_GREEN)
      ew_pend_d = 1'b0;
    else if (ew_sensor && state_q != S_EW_GREEN)
      ew_pend_d = 1'b1;

    ped_pend_d = ped_pend_q;
    if (entering && state_d == S_WALK)
      ped_pend_d = 1'b0;
    else if (ped_req && state_q != S_WALK)
      ped_pend_d = 1'b1;

    // Lamps are decoded from the next state so the registered lamps line up with phase
    ns_light_d = LAMP_RED;
    ew_light_d = LAMP_RED;
    walk_d     = 1'b0;
    case (state_d)
      S_NS_GREEN:  ns_light_d = LAMP_GREEN;
      S_NS_YELLOW: ns_light_d = LAMP_YELLOW;
      S_EW_GREEN:  ew_light_d = LAMP_GREEN;
      S_EW_YELLOW: ew_light_d = LAMP_YELLOW;
      S_WALK:      walk_d     = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_NS_GREEN;
      time_q     <= GREEN_LD;
      ew_pend_q  <= 1'b0;
      ped_pend_q <= 1'b0;
      ns_light_q <= LAMP_GREEN;
      ew_light_q <= LAMP_RED;
      walk_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      ew_pend_q  <= ew_pend_d;
      ped_pend_q <= ped_pend_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      walk_q     <= walk_d;
    end
  end

  assign ns_light  = ns_light_q;
  assign ew_light  = ew_light_q;
  assign walk      = walk_q;
  assign phase     = state_q;
  assign time_left = time_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller with short phase durations.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       ew_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk;
  logic [4:0] time_left;

  int checks = 0;
  int errors = 0;

  traffic_light_controller #(
    .COUNT_SIZE(5), .GREEN_TIME(3), .YELLOW_TIME(2), .ALLRED_TIME(1), .WALK_TIME(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .ew_sensor(ew_sensor), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .phase(phase),
    .time_left(time_left)
  );

  always #5 clk = ~clk;

  // Safety invariant: never both roads non-red
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
        errors++;
        $display("FAIL invariant ns_light=%b ew_light=%b phase=%0d", ns_light, ew_light, phase);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; ew_sensor = 1'b0; ped_req = 1'b0; tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (phase !== 3'd0 || time_left !== 5'd3 || ns_light !== 3'b001 ||
        ew_light !== 3'b100 || walk !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got phase=%0d tl=%0d ns=%b ew=%b walk=%b expected 0 3 001 100 0",
               phase, time_left, ns_light, ew_light, walk);
    end
  endtask

  task automatic test_idle();
    int exp_tl [5] = '{3, 2, 1, 0, 0};
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      checks++;
      if (phase !== 3'd0) begin
        errors++;
        $display("FAIL idle_phase cycle %0d got %0d expected 0", i, phase);
      end
      if (i < 5) begin
        checks++;
        if (time_left !== 5'(exp_tl[i])) begin
          errors++;
          $display("FAIL idle_timer cycle %0d got %0d expected %0d", i, time_left, exp_tl[i]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (time_left !== 5'd0 || ns_light !== 3'b001 || ew_light !== 3'b100 || walk !== 1'b0) begin
      errors++;
      $display("FAIL idle_final got tl=%0d ns=%b ew=%b walk=%b expected 0 001 100 0",
               time_left, ns_light, ew_light, walk);
    end
  endtask

  task automatic test_ew();
    int exp_ph [24] = '{0,0,0,0,1,1,1,2,2,3,3,3,3,4,4,4,5,5,0,0,0,0,0,0};
    logic [2:0] exp_ew;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      exp_ew = (exp_ph[i] == 3) ? 3'b001 : (exp_ph[i] == 4) ? 3'b010 : 3'b100;
      checks++;
      if (phase !== 3'(exp_ph[i]) || ew_light !== exp_ew || walk !== 1'b0) begin
        errors++;
        $display("FAIL ew_seq step %0d got phase=%0d ew=%b walk=%b expected %0d %b 0",
                 i, phase, ew_light, walk, exp_ph[i], exp_ew);
      end
      // sensor pulse at start, then a pulse during EW green that must be ignored
      ew_sensor = (i == 0 || i == 10);
      @(negedge clk);
    end
    ew_sensor = 1'b0;
  endtask

  task automatic test_ped();
    int exp_ph [20] = '{0,0,0,0,1,1,1,2,2,6,6,6,0,0,0,0,0,0,0,0};
    logic [2:0] exp_ns;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      exp_ns = (exp_ph[i] == 0) ? 3'b001 : (exp_ph[i] == 1) ? 3'b010 : 3'b100;
      checks++;
      if (phase !== 3'(exp_ph[i]) || walk !== (exp_ph[i] == 6) ||
          ns_light !== exp_ns || ew_light !== 3'b100) begin
        errors++;
        $display("FAIL ped_seq step %0d got phase=%0d walk=%b ns=%b ew=%b expected %0d %0d %b 100",
                 i, phase, walk, ns_light, ew_light, exp_ph[i], exp_ph[i] == 6, exp_ns);
      end
      ped_req = (i == 0 || i == 10);
      @(negedge clk);
    end
    ped_req = 1'b0;
  endtask

  task automatic test_both();
    int exp_ph [24] = '{0,0,0,0,1,1,1,2,2,3,3,3,3,4,4,4,5,5,6,6,6,0,0,0};
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (phase !== 3'(exp_ph[i]) || walk !== (exp_ph[i] == 6)) begin
        errors++;
        $display("FAIL both_seq step %0d got phase=%0d walk=%b expected %0d %0d",
                 i, phase, walk, exp_ph[i], exp_ph[i] == 6);
      end
      ew_sensor = (i == 0);
      ped_req   = (i == 0);
      @(negedge clk);
    end
    ew_sensor = 1'b0;
    ped_req   = 1'b0;
  endtask

  task automatic test_slow_tick();
    int exp_ph [22] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,2};
    int exp_tl [22] = '{3,3,3,3,2,2,2,2,1,1,1,1,0,2,2,2,1,1,1,1,0,1};
    apply_reset();
    ew_sensor = 1'b1;
    tick = 1'b0;
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (phase !== 3'(exp_ph[i]) || time_left !== 5'(exp_tl[i])) begin
        errors++;
        $display("FAIL slow_tick step %0d got phase=%0d tl=%0d expected %0d %0d",
                 i, phase, time_left, exp_ph[i], exp_tl[i]);
      end
      tick = ((i + 1) % 4 == 0);
      @(negedge clk);
    end
    ew_sensor = 1'b0;
    tick = 1'b1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ew_sensor = 1'b1;
    @(negedge clk);
    ew_sensor = 1'b0;
    repeat (9) @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL reset_mid_pre got phase=%0d expected 3", phase);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (phase !== 3'd0 || time_left !== 5'd3 || ns_light !== 3'b001 ||
        ew_light !== 3'b100 || walk !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got phase=%0d tl=%0d ns=%b ew=%b walk=%b expected 0 3 001 100 0",
               phase, time_left, ns_light, ew_light, walk);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (phase !== 3'd0) begin
        errors++;
        $display("FAIL reset_mid_pend step %0d got phase=%0d expected 0", i, phase);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ew();
    test_ped();
    test_both();
    test_slow_tick();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
